// File: rtl/datapath.sv
// datapath -- multicycle MIPS32 subset core with a single unified memory port.
//
// Instructions live in bytes 0x00-0x7C and data in 0x80-0xFC of the same
// memory. Only one memory access happens per cycle. Each instruction moves
// through a sequence of states, so it takes several clocks.
//
// Ports:
//   clk          sole clock; all state changes on its rising edge
//   reset        synchronous, active-low; forces PC/state/all registers to 0
//   memdata      read data from memory (combinational function of memadd)
//   memadd       byte address to memory (PC, or ALUOut in MEMRD/MEMWR)
//   outdata      store data to memory (always the B register)
//   writeDataEN  memory write strobe, high only in MEMWR
//   stopf        halt flag, high while the core sits in HALT

module datapath (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memdata,
   output logic [31:0] memadd,
   output logic [31:0] outdata,
   output logic        writeDataEN,
   output logic        stopf
);

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      REXE,
      RWB,
      BEQEX,
      ADDIEX,
      ADDIWB,
      JEX,
      HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   state_t      state_q, state_d;
   logic [31:0] pc_q,    pc_d;
   logic [31:0] ir_q,    ir_d;
   logic [31:0] a_q,     a_d;
   logic [31:0] b_q,     b_d;
   logic [31:0] alu_q,   alu_d;
   logic [31:0] mdr_q,   mdr_d;
   logic [31:0] rf_q [32];

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic [31:0] memadd_c;
   logic        wen_c;
   logic        stop_c;

   // Instruction fields
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic [5:0]  funct;
   logic [31:0] simm;
   logic        funct_ok;
   logic [31:0] rs_val, rt_val;
   logic [31:0] rtype_res;

   assign opcode = ir_q[31:26];
   assign rs     = ir_q[25:21];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign funct  = ir_q[5:0];
   assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};

   assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);

   // $0 is never written, but the read is forced to zero anyway so the
   // zero register does not depend on write-port gating alone.
   assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
   assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];

   always_comb begin
      rtype_res = '0;
      case (funct)
         FN_ADD:  rtype_res = a_q + b_q;
         FN_SUB:  rtype_res = a_q - b_q;
         FN_AND:  rtype_res = a_q & b_q;
         FN_OR:   rtype_res = a_q | b_q;
         FN_SLT:  rtype_res = {31'd0, ($signed(a_q) < $signed(b_q))};
         default: rtype_res = '0;
      endcase
   end

   // Next-state and output logic
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      rf_we    = 1'b0;
      rf_waddr = rd;
      rf_wdata = alu_q;
      memadd_c = pc_q;
      wen_c    = 1'b0;
      stop_c   = 1'b0;

      case (state_q)
         FETCH: begin
            ir_d    = memdata;
            pc_d    = pc_q + 32'd4;
            state_d = DECODE;
         end

         DECODE: begin
            a_d   = rs_val;
            b_d   = rt_val;
            // Branch target computed speculatively; BEQEX only commits it.
            alu_d = pc_q + (simm << 2);
            case (opcode)
               OP_RTYPE: state_d = funct_ok ? REXE : FETCH;
               OP_LW,
               OP_SW:    state_d = MEMADR;
               OP_BEQ:   state_d = BEQEX;
               OP_ADDI:  state_d = ADDIEX;
               OP_J:     state_d = JEX;
               OP_HALT:  state_d = HALT;
               default:  state_d = FETCH;
            endcase
         end

         MEMADR: begin
            alu_d   = a_q + simm;
            state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         end

         MEMRD: begin
            memadd_c = alu_q;
            mdr_d    = memdata;
            state_d  = MEMWB;
         end

         MEMWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = mdr_q;
            state_d  = FETCH;
         end

         MEMWR: begin
            memadd_c = alu_q;
            wen_c    = 1'b1;
            state_d  = FETCH;
         end

         REXE: begin
            alu_d   = rtype_res;
            state_d = RWB;
         end

         RWB: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = alu_q;
            state_d  = FETCH;
         end

         BEQEX: begin
            if (a_q == b_q) pc_d = alu_q;
            state_d = FETCH;
         end

         ADDIEX: begin
            alu_d   = a_q + simm;
            state_d = ADDIWB;
         end

         ADDIWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = alu_q;
            state_d  = FETCH;
         end

         JEX: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = FETCH;
         end

         HALT: begin
            stop_c  = 1'b1;
            state_d = HALT;
         end

         default: state_d = FETCH;
      endcase
   end

   // Reset is sampled on the clock, but outputs are also masked while it is
   // low so the memory sees address 0 and no strobe during the whole reset.
   assign memadd      = reset ? memadd_c : '0;
   assign writeDataEN = reset & wen_c;
   assign stopf       = reset & stop_c;
   assign outdata     = b_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         for (int unsigned i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
         if (rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
         end
      end
   end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath -- directed and random programs for the datapath core.
// An instruction-level interpreter predicts every memory store (address,
// data, cycle) and the cycle at which stopf rises; the bench's memory model
// logs what the core actually writes and compares.

module tb_datapath;

   logic        clk;
   logic        reset;
   logic [31:0] memdata;
   logic [31:0] memadd;
   logic [31:0] outdata;
   logic        writeDataEN;
   logic        stopf;

   logic [31:0] mem [64];

   int total = 0;
   int bad   = 0;

   logic [31:0] ow_addr [$];
   logic [31:0] ow_data [$];
   int          ow_cyc  [$];
   logic [31:0] ew_addr [$];
   logic [31:0] ew_data [$];
   int          ew_cyc  [$];
   int          obs_halt;
   int          exp_halt;
   logic [31:0] exp_halt_pc;

   localparam logic [31:0] HALT_I = 32'hFC00_0000;

   datapath dut (
      .clk        (clk),
      .reset      (reset),
      .memdata    (memdata),
      .memadd     (memadd),
      .outdata    (outdata),
      .writeDataEN(writeDataEN),
      .stopf      (stopf)
   );

   assign memdata = (memadd[31:8] == 24'd0) ? mem[memadd[7:2]] : 32'd0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(int byte_addr);
      return {6'h02, 26'(byte_addr >> 2)};
   endfunction

   function automatic logic [31:0] obs_a(int i);
      return (i < ow_addr.size()) ? ow_addr[i] : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] obs_d(int i);
      return (i < ow_data.size()) ? ow_data[i] : 32'hFFFF_FFFF;
   endfunction
   function automatic int obs_c(int i);
      return (i < ow_cyc.size()) ? ow_cyc[i] : -1;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = '0;
   endtask

   // Instruction-level interpreter with per-instruction cycle costs.
   task automatic model_run();
      logic [31:0] m [64];
      logic [31:0] r [32];
      logic [31:0] pc, ins, sv, addr, res;
      int cyc, rs, rt, rd;
      bit ok;
      ew_addr.delete(); ew_data.delete(); ew_cyc.delete();
      for (int i = 0; i < 64; i++) m[i] = mem[i];
      for (int i = 0; i < 32; i++) r[i] = '0;
      pc = '0; cyc = 0; exp_halt = -1; exp_halt_pc = '0;
      for (int n = 0; n < 500 && exp_halt < 0; n++) begin
         ins = (pc < 32'd256) ? m[pc[7:2]] : 32'd0;
         pc  = pc + 32'd4;
         rs  = int'(ins[25:21]);
         rt  = int'(ins[20:16]);
         rd  = int'(ins[15:11]);
         sv  = {{16{ins[15]}}, ins[15:0]};
         case (ins[31:26])
            6'h00: begin
               ok  = 1'b1;
               res = '0;
               case (ins[5:0])
                  6'h20: res = r[rs] + r[rt];
                  6'h22: res = r[rs] - r[rt];
                  6'h24: res = r[rs] & r[rt];
                  6'h25: res = r[rs] | r[rt];
                  6'h2A: res = (int'(r[rs]) < int'(r[rt])) ? 32'd1 : 32'd0;
                  default: ok = 1'b0;
               endcase
               if (ok) begin
                  if (rd != 0) r[rd] = res;
                  cyc += 4;
               end else cyc += 2;
            end
            6'h23: begin
               addr = r[rs] + sv;
               if (rt != 0) r[rt] = (addr < 32'd256) ? m[addr[7:2]] : 32'd0;
               cyc += 5;
            end
            6'h2B: begin
               addr = r[rs] + sv;
               ew_addr.push_back(addr);
               ew_data.push_back(r[rt]);
               ew_cyc.push_back(cyc + 3);
               if (addr < 32'd256) m[addr[7:2]] = r[rt];
               cyc += 4;
            end
            6'h04: begin
               if (r[rs] == r[rt]) pc = pc + (sv * 4);
               cyc += 3;
            end
            6'h08: begin
               if (rt != 0) r[rt] = r[rs] + sv;
               cyc += 4;
            end
            6'h02: begin
               pc = {pc[31:28], ins[25:0], 2'b00};
               cyc += 3;
            end
            6'h3F: begin
               exp_halt    = cyc + 2;
               exp_halt_pc = pc;
            end
            default: cyc += 2;
         endcase
      end
   endtask

   // Entered just after a rising edge; holds reset low for two edges.
   task automatic hold_reset();
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_memadd", memadd, 32'd0);
         chk("rst_wen", 32'(writeDataEN), 32'd0);
         chk("rst_stopf", 32'(stopf), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   // Releases reset, runs until stopf or budget, compares against the model.
   task automatic run_dut(input string name, input int budget);
      ow_addr.delete(); ow_data.delete(); ow_cyc.delete();
      obs_halt = -1;
      reset = 1'b1;
      for (int k = 0; k < budget && obs_halt < 0; k++) begin
         @(negedge clk);
         if (k == 0) chk({name, "_first_fetch"}, memadd, 32'd0);
         if (k == 1) chk({name, "_pc_plus4"}, memadd, 32'd4);
         if (writeDataEN) begin
            ow_addr.push_back(memadd);
            ow_data.push_back(outdata);
            ow_cyc.push_back(k);
            if (memadd < 32'd256) mem[memadd[7:2]] = outdata;
         end
         if (stopf) obs_halt = k;
         @(posedge clk); #1;
      end
      chk({name, "_nwrites"}, ow_addr.size(), ew_addr.size());
      for (int i = 0; i < ew_addr.size(); i++) begin
         chk($sformatf("%s_w%0d_addr", name, i), obs_a(i), ew_addr[i]);
         chk($sformatf("%s_w%0d_data", name, i), obs_d(i), ew_data[i]);
         chk($sformatf("%s_w%0d_cyc", name, i), obs_c(i), ew_cyc[i]);
      end
      chk({name, "_halt_cyc"}, obs_halt, exp_halt);
      repeat (3) begin
         @(negedge clk);
         chk({name, "_halt_stopf"}, 32'(stopf), 32'd1);
         chk({name, "_halt_wen"}, 32'(writeDataEN), 32'd0);
         chk({name, "_halt_pc"}, memadd, exp_halt_pc);
         @(posedge clk); #1;
      end
   endtask

   task automatic gen_random();
      int sel, rs, rt, rd, lim;
      for (int i = 0; i < 64; i++) mem[i] = (i >= 32) ? $urandom : 32'd0;
      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 9);
         rs  = $urandom_range(0, 7);
         rt  = $urandom_range(0, 7);
         rd  = $urandom_range(0, 7);
         case (sel)
            0, 1: mem[i] = enc_i(8, rs, rt, $urandom_range(0, 65535));
            2:    mem[i] = enc_r(rs, rt, rd, 32'h20);
            3: begin
               case ($urandom_range(0, 3))
                  0:       mem[i] = enc_r(rs, rt, rd, 32'h22);
                  1:       mem[i] = enc_r(rs, rt, rd, 32'h24);
                  2:       mem[i] = enc_r(rs, rt, rd, 32'h25);
                  default: mem[i] = enc_r(rs, rt, rd, 32'h2A);
               endcase
            end
            4: mem[i] = enc_i(32'h23, 0, rt, 128 + 4 * $urandom_range(0, 31));
            5: mem[i] = enc_i(32'h2B, 0, rt, 128 + 4 * $urandom_range(0, 31));
            6: begin
               lim    = (23 - i < 3) ? 23 - i : 3;
               mem[i] = enc_i(4, rs, rt, $urandom_range(0, lim));
            end
            7: mem[i] = enc_j(4 * (i + 1 + $urandom_range(0, 23 - i)));
            8: mem[i] = enc_i(32'h0C, rs, rt, 5);
            default: mem[i] = enc_r(rs, rt, rd, 32'h26);
         endcase
      end
      mem[24] = HALT_I;
   endtask

   initial begin
      reset = 1'b0;
      clear_mem();

      // Arithmetic then a single store of the sum
      mem[0] = enc_i(8, 0, 1, 5);
      mem[1] = enc_i(8, 0, 2, 7);
      mem[2] = enc_r(1, 2, 3, 32'h20);
      mem[3] = enc_i(32'h2B, 0, 3, 128);
      mem[4] = HALT_I;
      hold_reset();
      model_run();
      run_dut("t28", 300);
      chk("t28_addr", obs_a(0), 32'h80);
      chk("t28_data", obs_d(0), 32'd12);
      chk("t28_gap", obs_halt - obs_c(0), 32'd3);

      // Load then store: 5 + 4 cycles
      clear_mem();
      mem[33] = 32'hAA;
      mem[0]  = enc_i(32'h23, 0, 4, 132);
      mem[1]  = enc_i(32'h2B, 0, 4, 136);
      mem[2]  = HALT_I;
      hold_reset();
      model_run();
      run_dut("t29", 300);
      chk("t29_addr", obs_a(0), 32'h88);
      chk("t29_data", obs_d(0), 32'hAA);
      chk("t29_wcyc", obs_c(0), 32'd8);

      // Signed compare and subtract from zero
      clear_mem();
      mem[0] = enc_i(8, 0, 1, -1);
      mem[1] = enc_r(1, 0, 2, 32'h2A);
      mem[2] = enc_r(0, 1, 3, 32'h22);
      mem[3] = enc_i(32'h2B, 0, 2, 128);
      mem[4] = enc_i(32'h2B, 0, 3, 132);
      mem[5] = HALT_I;
      hold_reset();
      model_run();
      run_dut("t30", 300);
      chk("t30_slt", obs_d(0), 32'd1);
      chk("t30_sub", obs_d(1), 32'd1);

      // Taken and untaken branch, $0 write, jump over a store
      clear_mem();
      mem[0] = enc_i(8, 0, 1, 3);
      mem[1] = enc_i(4, 1, 1, 1);
      mem[2] = enc_i(8, 0, 1, 9);
      mem[3] = enc_i(32'h2B, 0, 1, 128);
      mem[4] = enc_i(4, 1, 0, 1);
      mem[5] = enc_i(8, 0, 0, 5);
      mem[6] = enc_i(32'h2B, 0, 0, 132);
      mem[7] = enc_j(36);
      mem[8] = enc_i(32'h2B, 0, 1, 140);
      mem[9] = HALT_I;
      hold_reset();
      model_run();
      run_dut("t31", 300);
      chk("t31_beq_taken", obs_d(0), 32'd3);
      chk("t31_zero_reg", obs_d(1), 32'd0);

      // Reset while a store is in MEMADR: store must be abandoned
      clear_mem();
      mem[0]  = enc_i(8, 0, 1, 32'h55);
      mem[1]  = enc_i(32'h2B, 0, 1, 128);
      mem[2]  = HALT_I;
      mem[32] = 32'hDEAD_BEEF;
      hold_reset();
      reset = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         chk("t32_pre_wen", 32'(writeDataEN), 32'd0);
         if (k == 6) begin
            chk("t32_memadr_pc", memadd, 32'd8);
            reset = 1'b0;
         end
         @(posedge clk); #1;
      end
      repeat (2) begin
         @(negedge clk);
         chk("t32_rst_wen", 32'(writeDataEN), 32'd0);
         chk("t32_rst_memadd", memadd, 32'd0);
         chk("t32_rst_stopf", 32'(stopf), 32'd0);
         @(posedge clk); #1;
      end
      chk("t32_mem_kept", mem[32], 32'hDEAD_BEEF);
      model_run();
      run_dut("t32", 300);

      // Random programs
      for (int p = 0; p < 6; p++) begin
         gen_random();
         hold_reset();
         model_run();
         run_dut($sformatf("rnd%0d", p), 400);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 No parameters; data, address and register width fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-004 memdata  input  32  read data from unified memory; combinational function of memadd.
REQ-005 memadd  output  32  byte address to memory; word index = memadd[31:2].
REQ-006 outdata  output  32  store data to memory.
REQ-007 writeDataEN  output  1  memory write strobe; memory writes outdata at memadd on the rising edge where it is high.
REQ-008 stopf  output  1  halt flag; high once halt instruction executes.

Function
REQ-009 Multicycle MIPS32 core with unified memory: byte 0x00-0x7C instructions, 0x80-0xFC data; one memory access per cycle.
REQ-010 Supported: R-type (opcode 0) add/sub/and/or/slt (funct 0x20/0x22/0x24/0x25/0x2A), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02, halt 0x3F.
REQ-011 Register file 32x32, two combinational reads, one write; $0 reads 0, writes to $0 ignored.
REQ-012 Arithmetic 32-bit two's complement wrap, no overflow trap; slt signed; immediates sign-extended.
REQ-013 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXE, RWB, BEQEX, ADDIEX, ADDIWB, JEX, HALT.
REQ-014 FETCH: memadd=PC; IR<=memdata; PC<=PC+4; next DECODE.
REQ-015 DECODE: A<=reg[rs], B<=reg[rt]; ALUOut<=PC+(simm<<2); dispatch on opcode.
REQ-016 lw/sw: MEMADR ALUOut<=A+simm; lw: MEMRD (memadd=ALUOut, MDR<=memdata), MEMWB reg[rt]<=MDR; sw: MEMWR.
REQ-017 MEMWR: memadd=ALUOut, outdata=B, writeDataEN=1 for exactly this one cycle; next FETCH.
REQ-018 R-type: REXE ALUOut<=A op B; RWB reg[rd]<=ALUOut. addi: ADDIEX ALUOut<=A+simm; ADDIWB reg[rt]<=ALUOut.
REQ-019 beq: BEQEX PC<=ALUOut if A==B, else PC unchanged. j: JEX PC<={PC[31:28], imm26, 2'b00}.
REQ-020 Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-021 Unknown opcode or R-type funct: no state/register/memory change, return to FETCH after DECODE.
REQ-022 halt: DECODE -> HALT; HALT is terminal; stopf=1 continuously, writeDataEN=0, PC frozen, until reset.
REQ-023 writeDataEN=0 in every state except MEMWR; stopf=0 in every state except HALT.
REQ-024 memadd=PC in all states except MEMRD/MEMWR; outdata=B in all states.

Reset
REQ-025 reset low at rising edge: PC<=0, state<=FETCH, IR/A/B/ALUOut/MDR and all registers <=0; takes priority over any in-progress instruction (aborted, no write performed).
REQ-026 While reset low: writeDataEN=0, stopf=0, memadd=0; first fetch from address 0 on the first edge after reset returns high.

Verification
REQ-027 Hold reset low 2 cycles -> memadd=0x0, writeDataEN=0, stopf=0; release -> first IR load from byte 0.
REQ-028 addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,128($0); halt -> single writeDataEN pulse with memadd=0x80, outdata=12; stopf high 3 cycles after that pulse (FETCH, DECODE, HALT), stays high.
REQ-029 mem[0x84]=0xAA; lw $4,132($0); sw $4,136($0); halt -> write 0x000000AA to 0x88; 5+4 cycles between fetches confirmed.
REQ-030 addi $1,$0,-1; slt $2,$1,$0; sub $3,$0,$1; sw $2,128($0); sw $3,132($0) -> writes 1 and 1; sltu-style misuse forbidden (signed compare).
REQ-031 addi $1,$0,3; beq $1,$1,+1; addi $1,$0,9; sw $1,128($0); j to halt -> write value 3 (branch taken skips); beq with unequal operands falls through; addi $0,$0,5 leaves $0=0.
REQ-032 Assert reset low during MEMWR-bound sw (in MEMADR) -> no writeDataEN pulse, PC=0, execution restarts from 0.
